// File: rtl/fetch_unit.sv
// Byte-wide instruction fetch unit: prefetches from a 1-cycle synchronous memory into a small FIFO.
// Define FETCH_RESET_VECTOR_EN to take the start PC from the 6502 reset vector at FFFC/FFFD.
module fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] BOOT_PC    = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] addr_i,
  input  logic [7:0]  din_i,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [7:0]  instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   count_t;

`ifdef FETCH_RESET_VECTOR_EN
  typedef enum logic [1:0] {VEC_LO, VEC_HI, VEC_LD, RUN} state_t;
  localparam logic [15:0] RESET_ADDR = 16'hFFFC;
  state_t     state;
  logic [7:0] vec_lo;
  logic       run;
  assign run = (state == RUN);
`else
  localparam logic [15:0] RESET_ADDR = BOOT_PC;
  logic run;
  assign run = 1'b1;
`endif

  logic [15:0] pc;
  logic [15:0] tag;
  logic        inflight;
  ptr_t        rd_ptr, wr_ptr;
  count_t      count;
  logic [7:0]  fifo_data [FIFO_DEPTH];
  logic [15:0] fifo_pc   [FIFO_DEPTH];

  logic issue, push, pop;

  // Bytes already requested count against the buffer, so a response always has a free slot.
  assign issue = rst && run && !redirect &&
                 ((count + count_t'(inflight)) < count_t'(FIFO_DEPTH));
  assign push  = rst && inflight && !redirect;
  assign pop   = instr_valid && instr_ready;

  assign instr_valid = rst && (count != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : 8'h00;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : 16'h0000;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    addr_i = pc;
    if (!rst) begin
      addr_i = RESET_ADDR;
    end
`ifdef FETCH_RESET_VECTOR_EN
    else if (state == VEC_LO) begin
      addr_i = 16'hFFFC;
    end else if (state == VEC_HI) begin
      addr_i = 16'hFFFD;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= BOOT_PC;
      tag      <= 16'h0000;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
`ifdef FETCH_RESET_VECTOR_EN
      state    <= VEC_LO;
      vec_lo   <= 8'h00;
`endif
    end else if (redirect) begin
      // A transfer this cycle is already visible to the frontend; everything else is dropped.
      pc       <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
`ifdef FETCH_RESET_VECTOR_EN
      state    <= RUN;
`endif
    end else begin
`ifdef FETCH_RESET_VECTOR_EN
      case (state)
        VEC_LO: state <= VEC_HI;
        VEC_HI: begin
          vec_lo <= din_i;
          state  <= VEC_LD;
        end
        VEC_LD: begin
          pc    <= {din_i, vec_lo};
          state <= RUN;
        end
        default: ;
      endcase
`endif
      inflight <= issue;
      if (issue) begin
        pc  <= pc + 16'd1;
        tag <= pc;
      end
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      count <= count + count_t'(push) - count_t'(pop);
    end
  end

  // NOTE: the buffer storage carries no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= din_i;
      fifo_pc[wr_ptr]   <= tag;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed boot/backpressure/redirect/wrap/reset steps,
// then random ready/redirect/reset traffic scored against an in-order byte-stream model.
module tb_fetch_unit;

`ifdef FETCH_RESET_VECTOR_EN
  localparam logic [15:0] START_PC   = 16'h1234;
  localparam logic [15:0] RESET_ADDR = 16'hFFFC;
  localparam int          VEC        = 3;
`else
  localparam logic [15:0] START_PC   = 16'h0200;
  localparam logic [15:0] RESET_ADDR = 16'h0200;
  localparam int          VEC        = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_i;
  logic [7:0]  din;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_pc;
  logic        hold_prev = 1'b0;
  logic [7:0]  prev_instr;
  logic [15:0] prev_pc;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (addr_i),
    .din_i       (din),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'h1234: return 8'hA9;
      16'h1235: return 8'h05;
      16'h1236: return 8'h8D;
      default:  return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hC3;
    endcase
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) din <= mem_byte(addr_i);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample the settled cycle: idle zeros, hold-while-stalled, and in-order delivery.
  task automatic observe();
    #1;
    if (instr_valid !== 1'b1) begin
      check("idle_instr", {24'd0, instr}, 32'd0);
      check("idle_pc", {16'd0, instr_pc}, 32'd0);
    end
    if (hold_prev && rst) begin
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", {24'd0, instr}, {24'd0, prev_instr});
      check("hold_pc", {16'd0, instr_pc}, {16'd0, prev_pc});
    end
    if (instr_valid === 1'b1 && instr_ready) begin
      check("xfer_pc", {16'd0, instr_pc}, {16'd0, exp_pc});
      check("xfer_data", {24'd0, instr}, {24'd0, mem_byte(exp_pc)});
      exp_pc = exp_pc + 16'd1;
    end
  endtask

  task automatic advance();
    hold_prev  = rst && instr_valid && !instr_ready && !redirect;
    prev_instr = instr;
    prev_pc    = instr_pc;
    if (!rst) exp_pc = START_PC;
    else if (redirect) exp_pc = redirect_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      observe();
      advance();
    end
  endtask

  initial begin
    bit found;
    rst = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0;
    exp_pc = START_PC;
    @(posedge clk);
    #1;

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      observe();
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_addr", {16'd0, addr_i}, {16'd0, RESET_ADDR});
      advance();
    end

    // Boot: vector fetch (if built in), first request, 2-cycle latency, streaming.
    rst = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < VEC + 6; c++) begin
      observe();
      if (c == 0) check("boot_addr0", {16'd0, addr_i}, {16'd0, RESET_ADDR});
`ifdef FETCH_RESET_VECTOR_EN
      if (c == 1) check("boot_addr1", {16'd0, addr_i}, 32'h0000_FFFD);
`endif
      if (c == VEC) check("boot_first_req", {16'd0, addr_i}, {16'd0, START_PC});
      if (c == VEC + 1) check("boot_latency", {31'd0, instr_valid}, 32'd0);
      if (c >= VEC + 2) begin
        check("boot_stream_valid", {31'd0, instr_valid}, 32'd1);
        check("boot_stream_pc", {16'd0, instr_pc}, {16'd0, START_PC + 16'(c - (VEC + 2))});
      end
      advance();
    end

    // Backpressure: exactly FIFO_DEPTH requests, then gap-free drain and resume.
    rst = 1'b0; instr_ready = 1'b0;
    step(1);
    rst = 1'b1;
    step(VEC + 10);
    observe();
    check("bp_addr", {16'd0, addr_i}, {16'd0, START_PC + 16'd4});
    check("bp_valid", {31'd0, instr_valid}, 32'd1);
    check("bp_pc", {16'd0, instr_pc}, {16'd0, START_PC});
    check("bp_instr", {24'd0, instr}, {24'd0, mem_byte(START_PC)});
    advance();
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      observe();
      check("drain_valid", {31'd0, instr_valid}, 32'd1);
      check("drain_pc", {16'd0, instr_pc}, {16'd0, START_PC + 16'(i)});
      advance();
    end

    // Redirect with three buffered bytes plus one in flight.
    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
    step(1);
    redirect = 1'b0;
    step(4);
    redirect = 1'b1; redirect_pc = 16'h3000; instr_ready = 1'b1;
    observe();
    check("pre_redir_valid", {31'd0, instr_valid}, 32'd1);
    advance();
    redirect = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      observe();
      if (k == 1) check("redir_addr", {16'd0, addr_i}, 32'h0000_3000);
      if (k < 3) check("redir_gap", {31'd0, instr_valid}, 32'd0);
      if (k == 3) begin
        check("redir_valid", {31'd0, instr_valid}, 32'd1);
        check("redir_pc", {16'd0, instr_pc}, 32'h0000_3000);
      end
      advance();
    end

    // Back-to-back redirects: the later target wins.
    redirect = 1'b1; redirect_pc = 16'h5000;
    step(1);
    redirect_pc = 16'h6000;
    step(1);
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      observe();
      if (instr_valid === 1'b1 && !found) begin
        found = 1'b1;
        check("b2b_pc", {16'd0, instr_pc}, 32'h0000_6000);
      end
      advance();
    end
    check("b2b_seen", {31'd0, found}, 32'd1);

    // Address wrap FFFF -> 0000.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step(1);
    redirect = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      observe();
      if (k >= 3) begin
        check("wrap_valid", {31'd0, instr_valid}, 32'd1);
        check("wrap_pc", {16'd0, instr_pc}, {16'd0, 16'hFFFE + 16'(k - 3)});
      end
      advance();
    end

    // Reset for one cycle with the buffer full.
    instr_ready = 1'b0;
    step(10);
    rst = 1'b0;
    observe();
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    advance();
    rst = 1'b1;
    observe();
    check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("post_rst_addr", {16'd0, addr_i}, {16'd0, RESET_ADDR});
    advance();
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < VEC + 4; i++) begin
      observe();
      if (instr_valid === 1'b1 && !found) begin
        found = 1'b1;
        check("post_rst_first_pc", {16'd0, instr_pc}, {16'd0, START_PC});
      end
      advance();
    end
    check("post_rst_seen", {31'd0, found}, 32'd1);

    // Random traffic scored against the in-order stream model.
    for (int i = 0; i < 800; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFF0 + 16'($urandom_range(0, 15));
      else redirect_pc = 16'($urandom_range(0, 65535));
      rst = ($urandom_range(0, 99) != 0);
      step(1);
    end
    rst = 1'b1; redirect = 1'b0; instr_ready = 1'b1;
    step(VEC + 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the fetch buffer depth in bytes; it SHALL be a power of two, minimum 2.
REQ-002 Parameter BOOT_PC, default 16'h0200, is the start PC used when vector fetch is compiled out.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 addr_i  output  16  instruction memory byte address.
REQ-006 din_i  input  8  instruction memory data, valid the cycle after addr_i is presented (1-cycle synchronous read).
REQ-007 redirect  input  1  flush and restart fetch at redirect_pc.
REQ-008 redirect_pc  input  16  new fetch address, sampled when redirect=1.
REQ-009 instr  output  8  head opcode/operand byte to frontend.
REQ-010 instr_pc  output  16  address of instr.
REQ-011 instr_valid  output  1  instr/instr_pc valid.
REQ-012 instr_ready  input  1  frontend accepts byte; transfer when instr_valid and instr_ready are both 1.

Function
REQ-013 States: VEC_LO, VEC_HI, VEC_LD, RUN; transitions VEC_LO->VEC_HI->VEC_LD->RUN, one per cycle; RUN is terminal until reset.
REQ-014 VEC_LO drives addr_i=16'hFFFC; VEC_HI drives 16'hFFFD and captures din_i as low byte; VEC_LD captures din_i as high byte and loads PC={din_i,low}.
REQ-015 In RUN, addr_i SHALL equal PC combinationally; a request issues in a cycle iff count+inflight < FIFO_DEPTH and redirect=0.
REQ-016 On issue, PC increments by 1 with 16'hFFFF wrapping to 16'h0000; inflight set for the next cycle with tag = issued address.
REQ-017 Cycle after an issue, {din_i, tag} SHALL be pushed to the FIFO unless squashed; fetch latency addr_i->instr_valid is 2 cycles with an empty FIFO.
REQ-018 Back-to-back issue SHALL sustain one byte per cycle while instr_ready=1.
REQ-019 FIFO SHALL never overflow; push and pop in the same cycle are both performed, count unchanged.
REQ-020 instr_valid=1 iff count>0; when instr_valid=0, instr=8'h00 and instr_pc=16'h0000.
REQ-021 instr/instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-022 redirect=1 (any state): a transfer occurring that cycle completes; FIFO cleared, inflight response squashed, PC<=redirect_pc, state<=RUN; first new request issues the following cycle.
REQ-023 Back-to-back redirects: the later one wins; no byte from the earlier target is delivered.
REQ-024 redirect_pc is taken verbatim; no alignment or range check.

Reset
REQ-025 While rst=0 at a clock edge: state<=VEC_LO (or RUN with macro absent), FIFO empty, inflight=0, PC<=BOOT_PC.
REQ-026 During and after reset: instr_valid=0, instr=8'h00, instr_pc=16'h0000; addr_i=16'hFFFC (macro present) or BOOT_PC (absent).
REQ-027 Reset asserted mid-operation SHALL discard all buffered and inflight bytes; none delivered after release.

Configuration
REQ-028 Macro FETCH_RESET_VECTOR_EN: defined -> 6502 reset vector fetch per REQ-013/014; undefined -> VEC_* states and vector registers absent, reset enters RUN with PC=BOOT_PC, first request issued on the first cycle after reset release.

Verification
REQ-029 Macro on, memory FFFC=34, FFFD=12, 1234..=A9 05 8D; instr_ready=1 -> addr_i FFFC, FFFD, 1234; bytes A9@1234, 05@1235, 8D@1236 on consecutive cycles.
REQ-030 Macro off, BOOT_PC=0200, instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH (4) requests issued, instr holds byte@0200; then ready=1 -> 0200..0203 delivered in order, fetch resumes at 0204, no gaps or duplicates.
REQ-031 PC=FFFE, ready=1 -> bytes @FFFE, FFFF, 0000, 0001 delivered in order.
REQ-032 Buffer holding 3 bytes plus inflight, pulse redirect with redirect_pc=3000 -> next instr_valid byte is @3000 two cycles later; no pre-redirect byte appears.
REQ-033 Assert rst=0 for one cycle while FIFO full -> instr_valid=0 next cycle; macro on: addr_i=FFFC and vector refetched.
